// File: rtl/splitter_stream.sv
// splitter_stream: breaks one WIDTH-bit word into N = WIDTH/LANE lanes and
// streams them out one per cycle with valid/ready handshakes on both sides.
// A partial word is supported: in_cnt gives the number of lanes minus one.
// The next word is accepted on the same edge as the final lane of the
// current word, so words stream back-to-back with no bubble.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    synchronous active-low reset
//   in_valid   in_data/in_cnt hold a word to accept
//   in_ready   block accepts a word this cycle
//   in_data    word to split (WIDTH bits)
//   in_cnt     lanes to emit minus 1 (CW bits)
//   out_valid  out_data holds a valid lane
//   out_ready  downstream consumes the lane this cycle
//   out_data   current lane (LANE bits)
//   out_idx    position of the current lane, 0 = first emitted
//   out_last   current lane is the final lane of the word
module splitter_stream #(
    parameter int WIDTH     = 32,
    parameter int LANE      = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int N        = WIDTH / LANE,
    localparam int CW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANE-1:0]  out_data,
    output logic [CW-1:0]    out_idx,
    output logic             out_last
);

    generate
        if ((WIDTH % LANE) != 0 || N < 2) begin : g_bad_params
            $error("splitter_stream: WIDTH must be a multiple of LANE with at least 2 lanes");
        end
    endgenerate

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [N-1:0][LANE-1:0] word;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          idx;
    logic [CW-1:0]          cnt_in;
    logic                   in_fire;
    logic                   out_fire;

    // When N is a power of two every in_cnt code is legal; otherwise codes
    // above N-1 saturate so the block never reads past the last lane.
    generate
        if (N == (1 << CW)) begin : g_cnt_full
            assign cnt_in = in_cnt;
        end else begin : g_cnt_clamp
            assign cnt_in = (in_cnt > CW'(N - 1)) ? CW'(N - 1) : in_cnt;
        end
    endgenerate

    assign out_valid = (state == SHIFT);
    assign out_last  = out_valid && (idx == cnt);
    assign out_idx   = idx;
    assign out_fire  = out_valid && out_ready;
    assign in_fire   = in_valid && in_ready;

    // Lane order is a pure index mapping onto the packed lane array.
    generate
        if (MSB_FIRST) begin : g_msb
            assign out_data = word[CW'(N - 1) - idx];
        end else begin : g_lsb
            assign out_data = word[idx];
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = reset_n;
                if (in_fire) state_nxt = SHIFT;
            end
            SHIFT: begin
                // Refill only when the final lane leaves this very cycle.
                in_ready = reset_n && out_last && out_ready;
                if (out_fire && out_last && !in_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            word  <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                word <= in_data;
                cnt  <= cnt_in;
                idx  <= '0;
            end else if (out_fire) begin
                idx <= out_last ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_splitter_stream.sv
// Testbench for splitter_stream. Two instances (MSB-first and LSB-first)
// share one stimulus stream. A reference model keeps the expected lanes of
// the word currently held as a queue: accepting a word fills it, each output
// transfer pops the front. Expected in_ready follows from the queue contents.
module tb_splitter_stream;

    localparam int W  = 32;
    localparam int L  = 8;
    localparam int CW = 2;

    typedef struct {
        logic [L-1:0]  d;
        logic [CW-1:0] i;
        logic          l;
    } lane_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [CW-1:0] in_cnt;
    logic          out_ready;
    logic          m_in_ready, m_out_valid, m_out_last;
    logic [L-1:0]  m_out_data;
    logic [CW-1:0] m_out_idx;
    logic          l_in_ready, l_out_valid, l_out_last;
    logic [L-1:0]  l_out_data;
    logic [CW-1:0] l_out_idx;

    int tests = 0;
    int fails = 0;

    lane_t qm[$];
    lane_t ql[$];

    always #5 clk = ~clk;

    splitter_stream #(.WIDTH(W), .LANE(L), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_cnt(in_cnt), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_data(m_out_data), .out_idx(m_out_idx),
        .out_last(m_out_last)
    );

    splitter_stream #(.WIDTH(W), .LANE(L), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .in_cnt(in_cnt), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_data(l_out_data), .out_idx(l_out_idx),
        .out_last(l_out_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_side(input string side, input lane_t q[$], input logic rdy,
                            input logic vld, input logic [L-1:0] d,
                            input logic [CW-1:0] i, input logic lst, input logic exp_rdy);
        chk({side, "_in_ready"}, 32'(rdy), 32'(exp_rdy));
        chk({side, "_out_valid"}, 32'(vld), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({side, "_out_data"}, 32'(d), 32'(q[0].d));
            chk({side, "_out_idx"}, 32'(i), 32'(q[0].i));
            chk({side, "_out_last"}, 32'(lst), 32'(q[0].l));
        end else begin
            chk({side, "_out_last_idle"}, 32'(lst), 32'd0);
        end
    endtask

    // One cycle: drive inputs just after the edge, check at the falling
    // edge, then advance the model to what the next rising edge does.
    task automatic cyc(input logic rst_n, input logic iv, input logic [W-1:0] d,
                       input logic [CW-1:0] c, input logic ordy);
        logic  exp_rdy;
        logic  ofire;
        lane_t e;
        reset_n   = rst_n;
        in_valid  = iv;
        in_data   = d;
        in_cnt    = c;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = rst_n && (qm.size() == 0 || (qm.size() == 1 && ordy));
        chk_side("msb", qm, m_in_ready, m_out_valid, m_out_data, m_out_idx, m_out_last, exp_rdy);
        chk_side("lsb", ql, l_in_ready, l_out_valid, l_out_data, l_out_idx, l_out_last, exp_rdy);
        ofire = (qm.size() != 0) && ordy;
        if (!rst_n) begin
            qm.delete();
            ql.delete();
        end else begin
            if (ofire) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (iv && exp_rdy) begin
                for (int k = 0; k <= int'(c); k++) begin
                    e.i = CW'(k);
                    e.l = (k == int'(c));
                    e.d = L'(d >> (W - L * (k + 1)));
                    qm.push_back(e);
                    e.d = L'(d >> (L * k));
                    ql.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 1, 32'hFFFF_FFFF, 3, 1);
        cyc(0, 0, 0, 0, 0);

        // Full word, continuous ready: 12 34 56 78 / 78 56 34 12.
        cyc(1, 1, 32'h1234_5678, 3, 1);
        repeat (5) cyc(1, 0, 0, 0, 1);

        // Back-to-back words with in_valid held throughout.
        cyc(1, 1, 32'hAABB_CCDD, 3, 1);
        repeat (4) cyc(1, 1, 32'h1122_3344, 3, 1);
        repeat (4) cyc(1, 0, 0, 0, 1);

        // Output stalls mid-word.
        cyc(1, 1, 32'hDEAD_BEEF, 3, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 1);

        // Partial word of two lanes, then a single-lane word.
        cyc(1, 1, 32'hCAFE_F00D, 1, 1);
        repeat (3) cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 32'h5A00_00A5, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 1);

        // Reset mid-word discards the remaining lanes; in_valid held at
        // release must not resurrect the old word.
        cyc(1, 1, 32'h0102_0304, 3, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 32'h0102_0304, 3, 1);
        cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 1);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 39) != 0), $urandom_range(0, 1), $urandom,
                CW'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end
        repeat (6) cyc(1, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/splitter_stream.md
SPLITTER_STREAM -- requirements
Module: splitter_stream

Interface
REQ-001 Parameter WIDTH, default 32: input word width in bits.
REQ-002 Parameter LANE, default 8: output lane width in bits; N = WIDTH/LANE lanes per word.
REQ-003 Parameter MSB_FIRST, default 1: 1 emits the most significant lane first, 0 emits the least significant lane first.
REQ-004 Elaboration SHALL fail if WIDTH is not a multiple of LANE or N < 2; CW = clog2(N).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset; sampled only on rising clk edge.
REQ-007 in_valid  input  1  in_data/in_cnt hold a word to accept.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 in_data  input  WIDTH  word to split.
REQ-010 in_cnt  input  CW  number of lanes to emit minus 1 (0..N-1); partial words supported.
REQ-011 out_valid  output  1  out_data holds a valid lane.
REQ-012 out_ready  input  1  downstream consumes the lane this cycle.
REQ-013 out_data  output  LANE  current lane.
REQ-014 out_idx  output  CW  index of current lane within the word, 0 = first emitted.
REQ-015 out_last  output  1  current lane is the final lane of the word.

Function
REQ-016 A transfer occurs on an input when valid and ready are both 1 at a rising edge; same rule on the output.
REQ-017 States: IDLE (no word held) and SHIFT (word held, out_valid = 1).
REQ-018 In IDLE, in_ready SHALL be 1 (when reset_n = 1) and out_valid SHALL be 0.
REQ-019 On input transfer, the block SHALL register in_data and in_cnt, set out_idx = 0, enter SHIFT; out_valid rises the next cycle (latency 1 cycle).
REQ-020 MSB_FIRST=1: out_data = word[WIDTH-1-out_idx*LANE -: LANE]; MSB_FIRST=0: out_data = word[out_idx*LANE +: LANE].
REQ-021 out_last SHALL equal out_valid AND (out_idx == registered cnt).
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-023 Output transfer with out_last=0: out_idx increments by 1, remain in SHIFT.
REQ-024 In SHIFT, in_ready SHALL equal out_last AND out_ready (combinational); otherwise 0, and in_valid is ignored.
REQ-025 Output transfer with out_last=1 and in_valid=1: new word loaded the same edge, out_idx = 0, out_valid stays 1 (no bubble).
REQ-026 Output transfer with out_last=1 and in_valid=0: return to IDLE, out_valid = 0 next cycle.
REQ-027 Sustained throughput SHALL be one lane per cycle across word boundaries when out_ready=1 and in_valid=1.
REQ-028 in_cnt = 0 SHALL emit exactly one lane, with out_last=1.
REQ-029 in_cnt > N-1 cannot occur for power-of-two N; for other N, values above N-1 SHALL be treated as N-1.

Reset
REQ-030 While reset_n = 0 at a rising edge: state IDLE, out_valid 0, out_idx 0, stored word 0, stored cnt 0.
REQ-031 While reset_n = 0, in_ready SHALL be 0 and no input transfer occurs.
REQ-032 Reset asserted mid-word SHALL discard remaining lanes; no lane from that word appears after reset_n returns to 1.
REQ-033 First cycle after reset_n returns to 1: in_ready = 1, out_valid = 0.

Verification
REQ-034 Defaults, in_data=32'h12345678, in_cnt=3, out_ready=1: out_data 12,34,56,78 on 4 consecutive cycles, out_idx 0..3, out_last only on 78.
REQ-035 MSB_FIRST=0, same word: out_data 78,56,34,12; out_last on 12.
REQ-036 Back-to-back words AABBCCDD then 11223344, in_valid held, out_ready=1: 8 lanes on 8 consecutive cycles, in_ready pulses 1 only on the AA..DD last-lane cycle.
REQ-037 out_ready toggled 1,0,0,1 during word DEADBEEF: DE then AD held 2 extra cycles unchanged, then BE, EF; no lane lost or duplicated.
REQ-038 in_cnt=1 with word CAFEF00D: only CA, FE emitted, out_last on FE, then IDLE.
REQ-039 reset_n driven 0 after lane 2 of 01020304: out_valid 0 next cycle; after release, in_ready 1 and no 03/04 emitted.
